// File: rtl/param_memory.sv
// Single-port CPU memory with a write-protected ROM window, a power-on clear engine and a block-fill engine.
// One-cycle registered read; Ready=0 while the clear or fill engine owns the array, and CPU inputs are ignored then.
module param_memory #(
  parameter int                      ADDR_WIDTH     = 16,
  parameter int                      DATA_WIDTH     = 8,
  parameter logic [ADDR_WIDTH-1:0]   ROM_BASE       = 'hF000,
  parameter logic [ADDR_WIDTH-1:0]   ROM_TOP        = 'hFFFF,
  parameter bit                      CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0]   CLEAR_VALUE    = '0,
  parameter int                      WRITE_MODE     = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] DataIn,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  Ready,
  output logic                  WriteFault,
  input  logic                  FillStart,
  input  logic [ADDR_WIDTH-1:0] FillBase,
  input  logic [ADDR_WIDTH:0]   FillCount,
  input  logic [DATA_WIDTH-1:0] FillValue,
  output logic                  FillDone
);

  localparam int               DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_FILL} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [ADDR_WIDTH:0]     left;
  logic [DATA_WIDTH-1:0]   fill_val;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_dat;

  // An inverted window (base above top) disables protection entirely.
  function automatic logic is_prot(input logic [ADDR_WIDTH-1:0] a);
    return (ROM_BASE <= ROM_TOP) && (a >= ROM_BASE) && (a <= ROM_TOP);
  endfunction

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = Address;
    wr_dat  = DataIn;
    case (state)
      S_CLEAR: begin
        wr_addr = addr;
        wr_dat  = CLEAR_VALUE;
        wr_en   = !is_prot(addr);
      end
      S_FILL: begin
        wr_addr = addr;
        wr_dat  = fill_val;
        wr_en   = !is_prot(addr);
      end
      S_IDLE:  wr_en = Ready && WE && !is_prot(Address);
      default: wr_en = 1'b0;
    endcase
    if (RST) wr_en = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      addr       <= '0;
      left       <= '0;
      fill_val   <= '0;
      DataOut    <= '0;
      Ready      <= 1'b0;
      WriteFault <= 1'b0;
      FillDone   <= 1'b0;
    end else begin
      WriteFault <= 1'b0;
      FillDone   <= 1'b0;
      case (state)
        S_CLEAR: begin
          addr <= addr + 1'b1;
          if (addr == '1) begin
            state <= S_IDLE;
            Ready <= 1'b1;
          end
        end
        S_FILL: begin
          addr <= addr + 1'b1;
          left <= left - CNT_ONE;
          if (left == CNT_ONE) begin
            state    <= S_IDLE;
            Ready    <= 1'b1;
            FillDone <= 1'b1;
          end
        end
        default: begin
          // Ready=0 here only on the first cycle after a reset that skips the clear.
          if (!Ready) begin
            Ready <= 1'b1;
          end else begin
            if (WE) begin
              WriteFault <= is_prot(Address);
              if (WRITE_MODE == 1)      DataOut <= DataIn;
              else if (WRITE_MODE == 2) DataOut <= mem[Address];
            end else begin
              DataOut <= mem[Address];
            end
            if (FillStart) begin
              fill_val <= FillValue;
              addr     <= FillBase;
              left     <= FillCount;
              if (FillCount == '0) begin
                FillDone <= 1'b1;
              end else begin
                state <= S_FILL;
                Ready <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_memory.sv
// Drives four param_memory variants (three write modes plus an unprotected one) with shared stimulus
// and compares every cycle against a job-queue reference model, plus directed constant checks.
module tb_param_memory;

  logic       CLK = 1'b0;
  logic       RST, WE, FillStart;
  logic [7:0] Address, DataIn, FillBase, FillValue;
  logic [8:0] FillCount;

  logic [7:0] dout [4];
  logic       rdy [4];
  logic       wf  [4];
  logic       fd  [4];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    param_memory #(
      .ADDR_WIDTH(8), .DATA_WIDTH(8),
      .ROM_BASE((g == 3) ? 8'h01 : 8'hF0),
      .ROM_TOP((g == 3) ? 8'h00 : 8'hFF),
      .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'h00),
      .WRITE_MODE((g == 3) ? 0 : g)
    ) dut (
      .CLK(CLK), .RST(RST), .WE(WE), .Address(Address), .DataIn(DataIn),
      .DataOut(dout[g]), .Ready(rdy[g]), .WriteFault(wf[g]),
      .FillStart(FillStart), .FillBase(FillBase), .FillCount(FillCount),
      .FillValue(FillValue), .FillDone(fd[g])
    );
  end

  int passed = 0;
  int total  = 0;
  bit fd_seen;

  // Reference model: array contents per variant plus a queue of pending engine writes.
  logic [7:0] mm [4][256];
  logic [7:0] m_dout [4];
  logic       m_wf [4];
  logic       m_ready, m_fd, job_fill;
  int         jobq [$];

  function automatic bit prot(int g, int a);
    return (g != 3) && (a >= 'hF0) && (a <= 'hFF);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_step();
    int j, a, mode;
    logic [7:0] old;
    m_fd = 1'b0;
    for (int g = 0; g < 4; g++) m_wf[g] = 1'b0;
    if (RST) begin
      jobq.delete();
      for (int k = 0; k < 256; k++) jobq.push_back(k << 8);
      job_fill = 1'b0;
      m_ready  = 1'b0;
      for (int g = 0; g < 4; g++) m_dout[g] = 8'h00;
    end else if (jobq.size() > 0) begin
      j = jobq.pop_front();
      a = j >> 8;
      for (int g = 0; g < 4; g++) if (!prot(g, a)) mm[g][a] = 8'(j);
      if (jobq.size() == 0) begin
        m_ready = 1'b1;
        m_fd    = job_fill;
      end
    end else begin
      for (int g = 0; g < 4; g++) begin
        mode = (g == 3) ? 0 : g;
        old  = mm[g][Address];
        if (WE) begin
          m_wf[g] = prot(g, int'(Address));
          if (!prot(g, int'(Address))) mm[g][Address] = DataIn;
          if (mode == 1) m_dout[g] = DataIn;
          if (mode == 2) m_dout[g] = old;
        end else begin
          m_dout[g] = old;
        end
      end
      if (FillStart) begin
        if (FillCount == 0) begin
          m_fd = 1'b1;
        end else begin
          for (int i = 0; i < int'(FillCount); i++)
            jobq.push_back((((int'(FillBase) + i) % 256) << 8) | int'(FillValue));
          job_fill = 1'b1;
          m_ready  = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("dout%0d", g), 32'(dout[g]), 32'(m_dout[g]));
      chk($sformatf("ready%0d", g), 32'(rdy[g]), 32'(m_ready));
      chk($sformatf("wfault%0d", g), 32'(wf[g]), 32'(m_wf[g]));
      chk($sformatf("fdone%0d", g), 32'(fd[g]), 32'(m_fd));
    end
    if (fd[0]) fd_seen = 1'b1;
  endtask

  task automatic rd(input logic [7:0] a);
    WE = 1'b0; Address = a; FillStart = 1'b0;
    tick();
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    WE = 1'b1; Address = a; DataIn = d; FillStart = 1'b0;
    tick();
    WE = 1'b0;
  endtask

  task automatic start_fill(input logic [7:0] b, input logic [8:0] c, input logic [7:0] v);
    WE = 1'b0; FillStart = 1'b1; FillBase = b; FillCount = c; FillValue = v;
    tick();
    FillStart = 1'b0;
  endtask

  // Counts cycles until Ready rises; a cap of 400 stands in for a hang.
  task automatic wait_ready(output int n);
    WE = 1'b0; FillStart = 1'b0;
    n = 0;
    while (!rdy[0] && n < 400) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    logic [7:0] v;
    logic [31:0] r;
    RST = 1'b1; WE = 1'b0; Address = '0; DataIn = '0;
    FillStart = 1'b0; FillBase = '0; FillCount = '0; FillValue = '0;
    fd_seen = 1'b0;
    for (int a = 0; a < 256; a++) begin
      v = (a == 'hF5) ? 8'hC3 : 8'h00;
      for (int g = 0; g < 4; g++) mm[g][a] = v;
      g_dut[0].dut.mem[a] = v;
      g_dut[1].dut.mem[a] = v;
      g_dut[2].dut.mem[a] = v;
      g_dut[3].dut.mem[a] = v;
    end

    tick();
    chk("reset_ready", 32'(rdy[0]), 0);
    chk("reset_dout", 32'(dout[0]), 0);
    RST = 1'b0;
    wait_ready(n);
    chk("clear_len", n, 256);

    rd(8'h10); chk("clr_rd10", 32'(dout[0]), 32'h00);
    rd(8'hF5); chk("rom_kept", 32'(dout[0]), 32'hC3);
    chk("rom_none_cleared", 32'(dout[3]), 32'h00);

    wr(8'h10, 8'hA5); chk("wr_no_fault", 32'(wf[0]), 0);
    rd(8'h10); chk("rd_back", 32'(dout[0]), 32'hA5);

    wr(8'hF5, 8'h00); chk("prot_fault", 32'(wf[0]), 1);
    chk("unprot_no_fault", 32'(wf[3]), 0);
    rd(8'hF5); chk("fault_one_cycle", 32'(wf[0]), 0);
    chk("prot_kept", 32'(dout[0]), 32'hC3);

    fd_seen = 1'b0;
    start_fill(8'hEE, 9'd4, 8'h5A);
    chk("fill_busy", 32'(rdy[0]), 0);
    wait_ready(n);
    chk("fill_len", n, 4);
    chk("fill_done", 32'(fd[0]), 1);
    rd(8'hEE); chk("fill_EE", 32'(dout[0]), 32'h5A);
    rd(8'hEF); chk("fill_EF", 32'(dout[0]), 32'h5A);
    rd(8'hF0); chk("fill_F0_prot", 32'(dout[0]), 32'h00);
    chk("fill_F0_open", 32'(dout[3]), 32'h5A);
    rd(8'hF5); chk("fill_F5_prot", 32'(dout[0]), 32'hC3);

    start_fill(8'h30, 9'd0, 8'hEE);
    chk("fill0_done", 32'(fd[0]), 1);
    chk("fill0_ready", 32'(rdy[0]), 1);
    rd(8'h30); chk("fill0_pulse", 32'(fd[0]), 0);
    chk("fill0_nowrite", 32'(dout[0]), 32'h00);

    start_fill(8'hFE, 9'd4, 8'h11);
    wait_ready(n);
    chk("wrap_len", n, 4);
    rd(8'hFE); chk("wrap_FE", 32'(dout[3]), 32'h11);
    rd(8'hFF); chk("wrap_FF", 32'(dout[3]), 32'h11);
    chk("wrap_FF_prot", 32'(dout[0]), 32'h00);
    rd(8'h00); chk("wrap_00", 32'(dout[3]), 32'h11);
    rd(8'h01); chk("wrap_01", 32'(dout[3]), 32'h11);
    rd(8'h02); chk("wrap_02", 32'(dout[3]), 32'h00);

    wr(8'h20, 8'h77);
    wr(8'h21, 8'h33);
    rd(8'h20);
    wr(8'h21, 8'h44);
    chk("mode_hold", 32'(dout[0]), 32'h77);
    chk("mode_thru", 32'(dout[1]), 32'h44);
    chk("mode_rdfirst", 32'(dout[2]), 32'h33);

    start_fill(8'h80, 9'd256, 8'hA0);
    wait_ready(n);
    chk("fill256_len", n, 256);
    rd(8'h7F); chk("fill256_last", 32'(dout[3]), 32'hA0);

    for (int c = 0; c < 800; c++) begin
      r = $urandom;
      WE        = r[0];
      Address   = (r[2:1] == 2'b00) ? {4'hF, r[6:3]} : 8'($urandom);
      DataIn    = 8'($urandom);
      FillStart = (r[11:8] == 4'h0);
      FillBase  = 8'($urandom);
      FillCount = 9'($urandom_range(0, 6));
      FillValue = 8'($urandom);
      tick();
    end

    wait_ready(n);
    fd_seen = 1'b0;
    start_fill(8'h40, 9'd10, 8'h99);
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("abort_ready", 32'(rdy[0]), 0);
    wait_ready(n);
    chk("abort_clear_len", n, 256);
    chk("abort_no_done", 32'(fd_seen), 0);
    rd(8'h41); chk("abort_cleared", 32'(dout[0]), 32'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
